// File: rtl/window3x3_pad_scan.sv
// window3x3_pad_scan
// Scans a WIDTH x HEIGHT frame out of the input block RAM in raster order and
// emits one 3x3 window per pixel (same-size output). Out-of-frame taps are
// padded. Downstream back-pressure is supported through oValid/iReady.
//
// Build option:
//   PAD_REPLICATE_EN  defined   : out-of-frame taps take the nearest in-frame pixel
//                     undefined : out-of-frame taps are 0
//
// Ports:
//   iClk, iRst     clock, asynchronous active-high reset
//   iStart         one-cycle frame start (ignored while busy or on the oDone cycle)
//   oBusy, oDone   frame in progress / one-cycle completion pulse
//   oCs, oAddr     BRAM read enable and raster address
//   iPixel         BRAM read data, valid one cycle after oCs
//   oWin           9 taps, tap k at [k*DATA_W +: DATA_W], k=0 top-left, k=4 centre
//   oValid, iReady window handshake
//   oFirst         marks the window centred on (0,0)
//
// State table:
//   IDLE  | waiting for iStart, no reads
//   SCAN  | reading pixels 0..DEPTH-1, emitting windows once primed
//   DRAIN | all pixels consumed, emitting the last WIDTH+1 windows
module window3x3_pad_scan #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 17,
  parameter int WIDTH  = 480,
  parameter int HEIGHT = 272
) (
  input  logic                iClk,
  input  logic                iRst,
  input  logic                iStart,
  output logic                oBusy,
  output logic                oDone,
  output logic                oCs,
  output logic [ADDR_W-1:0]   oAddr,
  input  logic [DATA_W-1:0]   iPixel,
  output logic [9*DATA_W-1:0] oWin,
  output logic                oValid,
  input  logic                iReady,
  output logic                oFirst
);

  localparam int DEPTH = WIDTH * HEIGHT;
  // Delay line long enough to hold the previous row, current row and next row
  // around a centre: the two line buffers plus the three tap columns.
  localparam int HIST  = 2 * WIDTH + 3;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int COL_W = $clog2(WIDTH);
  localparam int ROW_W = $clog2(HEIGHT);

  localparam logic [CNT_W-1:0]  PRIME_CNT = CNT_W'(WIDTH + 1);
  localparam logic [CNT_W-1:0]  LAST_PIX  = CNT_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(WIDTH - 1);
  localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(HEIGHT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state, nextState;

  logic [ADDR_W-1:0]   rdAddr;
  logic                readsDone;
  logic                rdPending;
  logic                holdValid;
  logic [DATA_W-1:0]   holdPix;
  logic [CNT_W-1:0]    pixCnt;
  logic [ROW_W-1:0]    cRow;
  logic [COL_W-1:0]    cCol;
  logic                producedLast;
  logic                winLast;

  logic                advance;
  logic                pixAvail;
  logic [DATA_W-1:0]   pixIn;
  logic [DATA_W-1:0]   shiftPix;
  logic                shiftEn;
  logic                emitWin;
  logic                finish;
  logic                startFrame;
  logic                lastCentre;

  logic [DATA_W-1:0]   hist     [HIST-1];
  logic [DATA_W-1:0]   histNext [HIST];
  logic [9*DATA_W-1:0] winNext;

  assign oAddr      = rdAddr;
  assign oBusy      = (state != IDLE);
  assign lastCentre = (cRow == LAST_ROW) && (cCol == LAST_COL);

  // A stalled output register freezes the whole pipe.
  assign advance    = !(oValid && !iReady);
  assign pixAvail   = holdValid || rdPending;
  assign pixIn      = holdValid ? holdPix : iPixel;
  assign shiftPix   = (state == SCAN) ? pixIn : '0;
  assign startFrame = (state == IDLE) && (nextState == SCAN);

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) state <= IDLE;
    else      state <= nextState;
  end

  always_comb begin
    nextState = state;
    oCs       = 1'b0;
    shiftEn   = 1'b0;
    emitWin   = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        // oDone high means the frame just ended this cycle; its iStart is dropped.
        if (iStart && !oDone) nextState = SCAN;
      end
      SCAN: begin
        oCs     = advance && !readsDone;
        shiftEn = advance && pixAvail;
        emitWin = shiftEn && (pixCnt >= PRIME_CNT);
        if (shiftEn && (pixCnt == LAST_PIX)) nextState = DRAIN;
      end
      DRAIN: begin
        shiftEn = advance && !producedLast;
        emitWin = shiftEn;
        if (oValid && iReady && winLast) begin
          finish    = 1'b1;
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    histNext[0] = shiftPix;
    for (int i = 1; i < HIST; i++) histNext[i] = hist[i-1];
  end

  // Entry j of histNext is the pixel consumed j shifts ago; the centre sits at
  // WIDTH+1, so tap (dr,dc) lives at WIDTH+1 - dr*WIDTH - dc.
  for (genvar k = 0; k < 9; k++) begin : gTap
    localparam int DR = k / 3 - 1;
    localparam int DC = k % 3 - 1;
    logic rowOut, colOut;
    logic [DATA_W-1:0] tap;
    assign rowOut = ((DR < 0) && (cRow == '0)) || ((DR > 0) && (cRow == LAST_ROW));
    assign colOut = ((DC < 0) && (cCol == '0)) || ((DC > 0) && (cCol == LAST_COL));
`ifdef PAD_REPLICATE_EN
    // Row and column clamp independently, so a corner collapses to the centre.
    assign tap = rowOut ? (colOut ? histNext[WIDTH+1] : histNext[WIDTH+1-DC])
                        : (colOut ? histNext[WIDTH+1-DR*WIDTH] : histNext[WIDTH+1-DR*WIDTH-DC]);
`else
    assign tap = (rowOut || colOut) ? '0 : histNext[WIDTH+1-DR*WIDTH-DC];
`endif
    assign winNext[k*DATA_W +: DATA_W] = tap;
  end

  always_ff @(posedge iClk) begin
    if (shiftEn) begin
      for (int i = 0; i < HIST - 1; i++) hist[i] <= histNext[i];
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      rdAddr       <= '0;
      readsDone    <= 1'b0;
      rdPending    <= 1'b0;
      holdValid    <= 1'b0;
      holdPix      <= '0;
      pixCnt       <= '0;
      cRow         <= '0;
      cCol         <= '0;
      producedLast <= 1'b0;
      winLast      <= 1'b0;
      oDone        <= 1'b0;
      oValid       <= 1'b0;
      oFirst       <= 1'b0;
      oWin         <= '0;
    end else begin
      oDone     <= finish;
      rdPending <= oCs;
      if (startFrame) begin
        rdAddr       <= '0;
        readsDone    <= 1'b0;
        holdValid    <= 1'b0;
        pixCnt       <= '0;
        cRow         <= '0;
        cCol         <= '0;
        producedLast <= 1'b0;
      end else begin
        if (oCs) begin
          if (rdAddr == LAST_ADDR) readsDone <= 1'b1;
          else                     rdAddr    <= rdAddr + 1'b1;
        end
        // A read issued just before a stall lands here instead of being lost.
        if (!advance && rdPending) begin
          holdPix   <= iPixel;
          holdValid <= 1'b1;
        end else if (shiftEn) begin
          holdValid <= 1'b0;
        end
        if (shiftEn && (state == SCAN)) pixCnt <= pixCnt + 1'b1;
        if (emitWin) begin
          if (lastCentre) producedLast <= 1'b1;
          if (cCol == LAST_COL) begin
            cCol <= '0;
            cRow <= cRow + 1'b1;
          end else begin
            cCol <= cCol + 1'b1;
          end
        end
      end
      if (advance) begin
        if (emitWin) begin
          oWin    <= winNext;
          oValid  <= 1'b1;
          oFirst  <= (cRow == '0) && (cCol == '0);
          winLast <= lastCentre;
        end else begin
          oValid  <= 1'b0;
          oFirst  <= 1'b0;
          winLast <= 1'b0;
        end
      end
    end
  end

endmodule
